// File: rtl/nw_pkg.sv
// rtl/nw_pkg.sv - shared types and cell-selection function for nw_seq_aligner
package nw_pkg;

    typedef enum logic [1:0] {
        DIR_UP   = 2'b00,
        DIR_LEFT = 2'b01,
        DIR_DIAG = 2'b10
    } dir_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        TRACE
    } state_t;

    // Candidates are sign-extended to this width so one function serves any score width.
    localparam int NW_CMP_W = 64;

    typedef struct packed {
        logic signed [NW_CMP_W-1:0] score;
        dir_t                       dir;
    } nw_cell_t;

    function automatic nw_cell_t nw_best(
        input logic signed [NW_CMP_W-1:0] diag,
        input logic signed [NW_CMP_W-1:0] up,
        input logic signed [NW_CMP_W-1:0] left
    );
        nw_cell_t r;
        if (diag >= up && diag >= left) begin
            r.score = diag;
            r.dir   = DIR_DIAG;
        end else if (up >= left) begin
            r.score = up;
            r.dir   = DIR_UP;
        end else begin
            r.score = left;
            r.dir   = DIR_LEFT;
        end
        return r;
    endfunction

endpackage

// File: rtl/nw_dir_store.sv
// rtl/nw_dir_store.sv - per-cell direction array, synchronous write, combinational read
module nw_dir_store
    import nw_pkg::*;
#(
    parameter int LENGTH = 10,
    localparam int AW = $clog2(LENGTH * LENGTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  dir_t          wdata,
    input  logic [AW-1:0] raddr,
    output dir_t          rdata
);

    dir_t mem [LENGTH*LENGTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/nw_seq_aligner.sv
// rtl/nw_seq_aligner.sv - one-cell-per-clock Needleman-Wunsch scorer with a row buffer
// Traceback storage and the tb_* stream exist only when NW_TRACEBACK_EN is defined.
module nw_seq_aligner
    import nw_pkg::*;
#(
    parameter int LENGTH      = 10,
    parameter int CWIDTH      = 2,
    parameter int SWIDTH      = 16,
    parameter int CORD_LENGTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [LENGTH*CWIDTH-1:0] s1,
    input  logic [LENGTH*CWIDTH-1:0] s2,
    input  logic signed [SWIDTH-1:0] match,
    input  logic signed [SWIDTH-1:0] mismatch,
    input  logic signed [SWIDTH-1:0] indel,
    output logic                     busy,
    output logic signed [SWIDTH-1:0] score,
    output logic                     score_valid,
    output logic                     done,
    output logic                     tb_valid,
    input  logic                     tb_ready,
    output logic [CORD_LENGTH-1:0]   tb_x,
    output logic [CORD_LENGTH-1:0]   tb_y,
    output logic                     tb_last
);

    localparam int LW = $clog2(LENGTH);
    localparam int RW = $clog2(LENGTH + 1);
    localparam logic [CORD_LENGTH-1:0] LAST_IDX = CORD_LENGTH'(LENGTH - 1);

    state_t state, state_nxt;

    logic [CWIDTH-1:0]        c1 [LENGTH];
    logic [CWIDTH-1:0]        c2 [LENGTH];
    logic signed [SWIDTH-1:0] match_r, mismatch_r, indel_r;
    // row_buf[0] is the column-0 boundary of the previous row; row_buf[j] holds H[.][j].
    logic signed [SWIDTH-1:0] row_buf [LENGTH+1];
    logic signed [SWIDTH-1:0] diag_r, left_r;
    logic [CORD_LENGTH-1:0]   x, y;

    logic [RW-1:0]            up_idx;
    logic signed [SWIDTH-1:0] h_diag, h_left, c_diag, c_up, c_left, cell_score;
    nw_cell_t                 best;
    logic                     last_cell;

    assign up_idx    = RW'(x) + 1'b1;
    assign last_cell = (x == LAST_IDX) && (y == LAST_IDX);
    assign busy      = (state != IDLE);

    always_comb begin
        h_diag     = (x == '0) ? row_buf[0] : diag_r;
        h_left     = (x == '0) ? row_buf[0] + indel_r : left_r;
        c_diag     = h_diag + ((c1[LW'(y)] == c2[LW'(x)]) ? match_r : mismatch_r);
        c_up       = row_buf[up_idx] + indel_r;
        c_left     = h_left + indel_r;
        best       = nw_best(NW_CMP_W'(c_diag), NW_CMP_W'(c_up), NW_CMP_W'(c_left));
        cell_score = SWIDTH'(best.score);
    end

`ifdef NW_TRACEBACK_EN
    localparam int DAW = $clog2(LENGTH * LENGTH);
    logic [DAW-1:0] cell_addr;
    dir_t           cur_dir;
    logic           trace_end;

    // FILL writes and TRACE reads share one address: the trace walks back with x/y.
    assign cell_addr = DAW'(int'(y) * LENGTH + int'(x));

    nw_dir_store #(.LENGTH(LENGTH)) u_dir_store (
        .clk   (clk),
        .we    (state == FILL),
        .waddr (cell_addr),
        .wdata (best.dir),
        .raddr (cell_addr),
        .rdata (cur_dir)
    );

    always_comb begin
        trace_end = 1'b0;
        case (cur_dir)
            DIR_DIAG: trace_end = (x == '0) || (y == '0);
            DIR_UP:   trace_end = (y == '0);
            default:  trace_end = (x == '0);
        endcase
    end

    assign tb_valid = (state == TRACE);
    assign tb_x     = tb_valid ? x : '0;
    assign tb_y     = tb_valid ? y : '0;
    assign tb_last  = tb_valid && trace_end;
`else
    logic unused_ok;
    assign unused_ok = tb_ready ^ (^best.dir);
    assign tb_valid  = 1'b0;
    assign tb_x      = '0;
    assign tb_y      = '0;
    assign tb_last   = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = FILL;
`ifdef NW_TRACEBACK_EN
            FILL:  if (last_cell) state_nxt = TRACE;
            TRACE: if (tb_ready && trace_end) state_nxt = IDLE;
`else
            FILL: if (last_cell) state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score       <= '0;
            score_valid <= 1'b0;
            done        <= 1'b0;
            x           <= '0;
            y           <= '0;
            match_r     <= '0;
            mismatch_r  <= '0;
            indel_r     <= '0;
            diag_r      <= '0;
            left_r      <= '0;
            for (int j = 0; j <= LENGTH; j++) row_buf[j] <= '0;
            for (int i = 0; i < LENGTH; i++) begin
                c1[i] <= '0;
                c2[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    score_valid <= 1'b0;
                    x           <= '0;
                    y           <= '0;
                    match_r     <= match;
                    mismatch_r  <= mismatch;
                    indel_r     <= indel;
                    for (int j = 0; j <= LENGTH; j++) row_buf[j] <= SWIDTH'(j) * indel;
                    for (int i = 0; i < LENGTH; i++) begin
                        c1[i] <= s1[i*CWIDTH +: CWIDTH];
                        c2[i] <= s2[i*CWIDTH +: CWIDTH];
                    end
                end
                FILL: begin
                    row_buf[up_idx] <= cell_score;
                    diag_r          <= row_buf[up_idx];
                    left_r          <= cell_score;
                    // The last cell leaves x/y at (L-1, L-1), where the traceback begins.
                    if (last_cell) begin
                        score       <= cell_score;
                        score_valid <= 1'b1;
`ifndef NW_TRACEBACK_EN
                        done        <= 1'b1;
`endif
                    end else if (x == LAST_IDX) begin
                        x          <= '0;
                        y          <= y + 1'b1;
                        row_buf[0] <= row_buf[0] + indel_r;
                    end else begin
                        x <= x + 1'b1;
                    end
                end
`ifdef NW_TRACEBACK_EN
                TRACE: if (tb_ready) begin
                    if (trace_end) begin
                        done <= 1'b1;
                    end else begin
                        case (cur_dir)
                            DIR_DIAG: begin
                                x <= x - 1'b1;
                                y <= y - 1'b1;
                            end
                            DIR_UP:  y <= y - 1'b1;
                            default: x <= x - 1'b1;
                        endcase
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nw_seq_aligner.sv
// tb/tb_nw_seq_aligner.sv - directed scoreboard bench for nw_seq_aligner at L=4
module tb_nw_seq_aligner;

    localparam int L  = 4;
    localparam int CW = 2;
    localparam int SW = 16;
    localparam int CL = 8;

    logic                 clk = 1'b0;
    logic                 reset, start, tb_ready;
    logic [L*CW-1:0]      s1, s2;
    logic signed [SW-1:0] match, mismatch, indel;
    logic                 busy, score_valid, done, tb_valid, tb_last;
    logic signed [SW-1:0] score;
    logic [CL-1:0]        tb_x, tb_y;

    nw_seq_aligner #(.LENGTH(L), .CWIDTH(CW), .SWIDTH(SW), .CORD_LENGTH(CL)) dut (
        .clk(clk), .reset(reset), .start(start), .s1(s1), .s2(s2),
        .match(match), .mismatch(mismatch), .indel(indel),
        .busy(busy), .score(score), .score_valid(score_valid), .done(done),
        .tb_valid(tb_valid), .tb_ready(tb_ready), .tb_x(tb_x), .tb_y(tb_y), .tb_last(tb_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CL-1:0] x;
        logic [CL-1:0] y;
        logic          last;
    } beat_t;

    logic [31:0] score_q [$];
    beat_t       beat_q  [$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic        saw_tbv  = 1'b0;

    always @(posedge clk) if (tb_valid === 1'b1) saw_tbv <= 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    endtask

    // Full-matrix reference: fills H and a direction grid, then walks back from (L,L).
    task automatic push_model(input logic [L*CW-1:0] a, input logic [L*CW-1:0] b,
                              input int m, input int mm, input int ind);
        int h [L+1][L+1];
        int d [L+1][L+1];
        int dg, up, lf, i, j;
        logic [CW-1:0] ca, cb;
        beat_t bt;
        for (int k = 0; k <= L; k++) begin
            h[k][0] = k * ind;
            h[0][k] = k * ind;
        end
        for (int r = 1; r <= L; r++) begin
            for (int c = 1; c <= L; c++) begin
                ca = a[(r-1)*CW +: CW];
                cb = b[(c-1)*CW +: CW];
                dg = h[r-1][c-1] + ((ca == cb) ? m : mm);
                up = h[r-1][c] + ind;
                lf = h[r][c-1] + ind;
                if (dg >= up && dg >= lf) begin h[r][c] = dg; d[r][c] = 2; end
                else if (up >= lf)        begin h[r][c] = up; d[r][c] = 0; end
                else                      begin h[r][c] = lf; d[r][c] = 1; end
            end
        end
        score_q.push_back(32'(SW'(h[L][L])));
        i = L;
        j = L;
        for (int n = 0; n < 2 * L; n++) begin
            bt.x = CL'(j - 1);
            bt.y = CL'(i - 1);
            if (d[i][j] == 2)      begin i--; j--; end
            else if (d[i][j] == 0) i--;
            else                   j--;
            bt.last = (i == 0) || (j == 0);
            beat_q.push_back(bt);
            if (bt.last) break;
        end
    endtask

    task automatic drive_start(input logic [L*CW-1:0] a, input logic [L*CW-1:0] b,
                               input int m, input int mm, input int ind);
        @(negedge clk);
        s1 = a; s2 = b;
        match = SW'(m); mismatch = SW'(mm); indel = SW'(ind);
        start = 1'b1;
        push_model(a, b, m, mm, ind);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        s1 = ~a; s2 = ~b;
        match = 16'sd7; mismatch = 16'sd5; indel = 16'sd3;
    endtask

    task automatic run_fill(input string tag, input logic [L*CW-1:0] a, input logic [L*CW-1:0] b,
                            input int m, input int mm, input int ind,
                            input bit has_spec, input int spec, input bit pulse);
        int cyc = 0;
        logic [31:0] exp = '0;
        drive_start(a, b, m, mm, ind);
        check({tag, " busy after start"}, 32'(busy), 32'(1));
        check({tag, " score_valid cleared"}, 32'(score_valid), 32'(0));
        while (score_valid !== 1'b1 && cyc < 40) begin
            if (pulse && cyc == 4) start = 1'b1;
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start = 1'b0;
        end
        check({tag, " latency"}, 32'(cyc), 32'(L * L));
        if (score_q.size() > 0) exp = score_q.pop_front();
        check({tag, " score"}, 32'(score), exp);
        if (has_spec) check({tag, " known score"}, 32'(score), 32'(spec));
`ifndef NW_TRACEBACK_EN
        check({tag, " done pulse"}, 32'(done), 32'(1));
        check({tag, " busy dropped"}, 32'(busy), 32'(0));
        @(posedge clk);
        @(negedge clk);
        check({tag, " done one cycle"}, 32'(done), 32'(0));
        check({tag, " score held"}, 32'(score_valid), 32'(1));
        beat_q.delete();
`endif
    endtask

`ifdef NW_TRACEBACK_EN
    task automatic run_trace(input string tag, input bit stall);
        int cyc = 0;
        int beat = 0;
        int stall_left = stall ? 3 : 0;
        bit fin = 1'b0;
        beat_t exp;
        while (!fin && cyc < 40) begin
            exp = (beat_q.size() > 0) ? beat_q[0] : '0;
            check($sformatf("%s beat%0d valid", tag, beat), 32'(tb_valid), 32'(1));
            check($sformatf("%s beat%0d x", tag, beat), 32'(tb_x), 32'(exp.x));
            check($sformatf("%s beat%0d y", tag, beat), 32'(tb_y), 32'(exp.y));
            check($sformatf("%s beat%0d last", tag, beat), 32'(tb_last), 32'(exp.last));
            tb_ready = !(beat == 1 && stall_left > 0);
            @(posedge clk);
            cyc++;
            if (tb_ready) begin
                if (beat_q.size() > 0) void'(beat_q.pop_front());
                beat++;
                if (exp.last) fin = 1'b1;
            end else begin
                stall_left--;
            end
            @(negedge clk);
        end
        tb_ready = 1'b0;
        check({tag, " trace finished"}, 32'(fin), 32'(1));
        check({tag, " done pulse"}, 32'(done), 32'(1));
        check({tag, " busy dropped"}, 32'(busy), 32'(0));
        check({tag, " tb_valid dropped"}, 32'(tb_valid), 32'(0));
        @(posedge clk);
        @(negedge clk);
        check({tag, " done one cycle"}, 32'(done), 32'(0));
    endtask
`endif

    initial begin
        reset = 1'b1; start = 1'b0; tb_ready = 1'b0;
        s1 = '0; s2 = '0; match = '0; mismatch = '0; indel = '0;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy), 32'(0));
        check("reset score", 32'(score), 32'(0));
        check("reset score_valid", 32'(score_valid), 32'(0));
        check("reset done", 32'(done), 32'(0));
        check("reset tb_valid", 32'(tb_valid), 32'(0));
        check("reset tb_x", 32'(tb_x), 32'(0));
        check("reset tb_y", 32'(tb_y), 32'(0));
        check("reset tb_last", 32'(tb_last), 32'(0));
        reset = 1'b0;

        // strings packed with char 0 in the low bits
        run_fill("identity", 8'b11_10_01_00, 8'b11_10_01_00, 1, -1, -1, 1'b1, 4, 1'b0);
`ifdef NW_TRACEBACK_EN
        run_trace("identity", 1'b0);
`endif
        run_fill("all_mismatch", 8'b00_00_00_00, 8'b01_01_01_01, 1, -1, -1, 1'b1, -4, 1'b0);
`ifdef NW_TRACEBACK_EN
        run_trace("all_mismatch", 1'b1);
`endif
        run_fill("shifted", 8'b11_10_01_00, 8'b00_11_10_01, 2, -3, -1, 1'b1, 4, 1'b0);
`ifdef NW_TRACEBACK_EN
        run_trace("shifted", 1'b0);
`endif

        drive_start(8'b01_11_00_10, 8'b10_01_11_00, 2, -1, -2);
        repeat (7) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midfill reset busy", 32'(busy), 32'(0));
        check("midfill reset score", 32'(score), 32'(0));
        @(negedge clk);
        check("midfill reset score_valid", 32'(score_valid), 32'(0));
        check("midfill reset done", 32'(done), 32'(0));
        check("midfill reset tb_valid", 32'(tb_valid), 32'(0));
        check("midfill reset tb_last", 32'(tb_last), 32'(0));
        score_q.delete();
        beat_q.delete();
        reset = 1'b0;

        run_fill("after_reset", 8'b01_11_00_10, 8'b10_01_11_00, 2, -1, -2, 1'b0, 0, 1'b0);
`ifdef NW_TRACEBACK_EN
        run_trace("after_reset", 1'b0);
`endif
        run_fill("start_in_fill", 8'b00_01_10_11, 8'b00_01_01_11, 3, -2, -1, 1'b0, 0, 1'b1);
`ifdef NW_TRACEBACK_EN
        run_trace("start_in_fill", 1'b0);
`endif

        for (int r = 0; r < 3; r++) begin
            logic [L*CW-1:0] ra, rb;
            int rm, rmm, rind;
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rm   = int'($urandom_range(4, 0));
            rmm  = int'($urandom_range(4, 0)) - 4;
            rind = int'($urandom_range(3, 0)) - 3;
            run_fill($sformatf("random%0d", r), ra, rb, rm, rmm, rind, 1'b0, 0, 1'b0);
`ifdef NW_TRACEBACK_EN
            run_trace($sformatf("random%0d", r), r == 1);
`endif
        end

`ifdef NW_TRACEBACK_EN
        check("tb_valid seen", 32'(saw_tbv), 32'(1));
`else
        check("tb_valid never asserted", 32'(saw_tbv), 32'(0));
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
